range_band_classifier: RTL and testbench

Streaming, parametrised range classifier for the conditional-logic block set. Each input sample is compared against NUM_BANDS programmable inclusive ranges. The result is reported with unique0-style semantics:
- zero matches is legal and flagged;
- more than one match is flagged as a uniqueness violation;
- the lowest-indexed matching band is returned.

The block is a 2-stage valid/ready pipeline with per-outcome saturating statistics counters. It sits between a sample producer and any policy/decision logic that consumes class indices.

---
 rtl/range_band_pkg.sv | 37 +++
 rtl/range_band_classifier_if.sv | 38 +++
 rtl/range_band_classifier_prio_enc.sv | 43 ++++
 rtl/range_band_classifier.sv | 211 +++++++++++++++++++++
 tb/tb_range_band_classifier.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/range_band_pkg.sv
// -----------------------------------------------------------------------------
// range_band_pkg
// Shared types and width helpers for the range band classifier and any other
// conditional-logic block that reuses the band priority encoder.
//   calc_class_w : width of a band index (at least 1 bit)
//   calc_sel_w   : width of the statistics counter select
//   prio_res_t   : priority-encoder result {cls, hit, multi}
// The band_t {lo, hi} struct depends on the sample width, so each user module
// builds it from its own WIDTH-based localparam typedef.
// -----------------------------------------------------------------------------
package range_band_pkg;

  // Upper bound on band-index width carried in the shared result struct.
  localparam int unsigned CLASS_MAX_W = 16;

  function automatic int calc_class_w(input int num_bands);
    int w;
    w = $clog2(num_bands);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  function automatic int calc_sel_w(input int num_bands);
    return $clog2(num_bands + 2);
  endfunction

  typedef struct packed {
    logic [CLASS_MAX_W-1:0] cls;
    logic                   hit;
    logic                   multi;
  } prio_res_t;

endpackage

// File: rtl/range_band_classifier_if.sv
// -----------------------------------------------------------------------------
// range_band_classifier_if
// Sample-in / result-out handshake bundle of the range band classifier.
//   in_valid/in_ready/in_data            : sample stream (producer -> block)
//   out_valid/out_ready/out_class/
//   out_hit/out_multi/out_match          : result stream (block -> consumer)
// Modports: slave = classifier side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface range_band_classifier_if
  import range_band_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_BANDS = 4
) ();

  localparam int CLASS_W = calc_class_w(NUM_BANDS);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CLASS_W-1:0]   out_class;
  logic                 out_hit;
  logic                 out_multi;
  logic [NUM_BANDS-1:0] out_match;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_class, out_hit, out_multi, out_match
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_hit, out_multi, out_match
  );

endinterface

// File: rtl/range_band_classifier_prio_enc.sv
// -----------------------------------------------------------------------------
// band_prio_enc
// Combinational priority encoder for a band match vector.
//   match_i : one bit per band, set when that band matched
//   res_o   : cls   = lowest set index (0 when none set)
//             hit   = popcount >= 1
//             multi = popcount >= 2
// -----------------------------------------------------------------------------
module band_prio_enc
  import range_band_pkg::*;
#(
  parameter int NUM_BANDS = 4
) (
  input  logic [NUM_BANDS-1:0] match_i,
  output prio_res_t            res_o
);

  // One spare bit so the constant 2 is representable even for a single band.
  localparam int POP_W = $clog2(NUM_BANDS + 1) + 1;

  logic [POP_W-1:0]       pop_s;
  logic [CLASS_MAX_W-1:0] cls_s;

  // Popcount and lowest-index search; scanning downward leaves the lowest hit.
  always_comb begin
    pop_s = '0;
    cls_s = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (match_i[i]) begin
        pop_s = pop_s + POP_W'(1);
        cls_s = CLASS_MAX_W'(i);
      end else begin
        pop_s = pop_s;
        cls_s = cls_s;
      end
    end
  end

  assign res_o.cls   = cls_s;
  assign res_o.hit   = (pop_s >= POP_W'(1));
  assign res_o.multi = (pop_s >= POP_W'(2));

endmodule

// File: rtl/range_band_classifier.sv
// -----------------------------------------------------------------------------
// range_band_classifier
// Streaming classifier: each sample is checked against NUM_BANDS programmable
// inclusive unsigned ranges; the lowest matching band is reported together
// with hit / multi-match flags, through a 2-stage valid/ready pipeline.
// Ports:
//   clk, rst       : rising-edge clock, asynchronous active-high reset
//   cfg_we_i       : write strobe for band cfg_idx_i bounds {cfg_lo_i, cfg_hi_i}
//   stat_clr_i     : synchronous clear of all statistics counters
//   stat_sel_i     : counter select (bands, then no-match, then multi)
//   stat_count_o   : selected counter value (combinational mux)
//   bus            : sample/result handshake interface (slave side)
// -----------------------------------------------------------------------------
module range_band_classifier
  import range_band_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int NUM_BANDS = 4,
  parameter  int CNT_W     = 16,
  localparam int CLASS_W   = calc_class_w(NUM_BANDS),
  localparam int SEL_W     = calc_sel_w(NUM_BANDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we_i,
  input  logic [CLASS_W-1:0]   cfg_idx_i,
  input  logic [WIDTH-1:0]     cfg_lo_i,
  input  logic [WIDTH-1:0]     cfg_hi_i,
  input  logic                 stat_clr_i,
  input  logic [SEL_W-1:0]     stat_sel_i,
  output logic [CNT_W-1:0]     stat_count_o,
  range_band_classifier_if.slave bus
);

  localparam int NUM_CNT = NUM_BANDS + 2;
  localparam int CNT_NM  = NUM_BANDS;
  localparam int CNT_MU  = NUM_BANDS + 1;

  typedef logic [WIDTH-1:0] bound_t;
  typedef struct packed {
    bound_t lo;
    bound_t hi;
  } band_t;

  band_t                bands_q [NUM_BANDS];
  logic [NUM_BANDS-1:0] match_s;

  logic                 s1_valid_q, s1_valid_d;
  logic [NUM_BANDS-1:0] s1_match_q, s1_match_d;

  logic                 out_valid_q, out_valid_d;
  logic [CLASS_W-1:0]   out_class_q, out_class_d;
  logic                 out_hit_q, out_hit_d;
  logic                 out_multi_q, out_multi_d;
  logic [NUM_BANDS-1:0] out_match_q, out_match_d;

  logic                 s2_adv_s;
  logic                 s1_adv_s;
  logic                 hs_s;
  prio_res_t            res_s;
  logic                 unused_cls_s;

  logic [NUM_CNT-1:0]   cnt_inc_s;
  logic [CNT_W-1:0]     cnt_all_s [NUM_CNT];

  // Band-bound registers; reset leaves every band disabled (lo > hi).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        bands_q[i].lo <= '1;
        bands_q[i].hi <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        // Indices beyond the last band never compare equal, so they are dropped.
        if (cfg_we_i && (cfg_idx_i == CLASS_W'(i))) begin
          bands_q[i].lo <= cfg_lo_i;
          bands_q[i].hi <= cfg_hi_i;
        end
      end
    end
  end

  // Inclusive unsigned range check of the incoming sample against every band.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      match_s[i] = (bus.in_data >= bands_q[i].lo) && (bus.in_data <= bands_q[i].hi);
    end
  end

  // A stage moves when its successor is empty or moving this cycle.
  assign s2_adv_s     = !out_valid_q || bus.out_ready;
  assign s1_adv_s     = !s1_valid_q || s2_adv_s;
  assign hs_s         = out_valid_q && bus.out_ready;
  assign bus.in_ready = s1_adv_s;

  band_prio_enc #(
    .NUM_BANDS (NUM_BANDS)
  ) u_prio_enc (
    .match_i (s1_match_q),
    .res_o   (res_s)
  );

  // Only the low CLASS_W bits of the shared-width class field are meaningful.
  assign unused_cls_s = ^res_s.cls;

  // Pipeline next-state: stage 1 captures the match vector, stage 2 the result.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_match_d  = s1_match_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_hit_d   = out_hit_q;
    out_multi_d = out_multi_q;
    out_match_d = out_match_q;

    if (s1_adv_s) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_match_d = match_s;
      end else begin
        s1_match_d = s1_match_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_class_d = res_s.cls[CLASS_W-1:0];
        out_hit_d   = res_s.hit;
        out_multi_d = res_s.multi;
        out_match_d = s1_match_q;
      end else begin
        out_class_d = out_class_q;
      end
    end else begin
      // Stalled with a valid result: every field holds until the handshake.
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_match_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_hit_q   <= 1'b0;
      out_multi_q <= 1'b0;
      out_match_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_match_q  <= s1_match_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_hit_q   <= out_hit_d;
      out_multi_q <= out_multi_d;
      out_match_q <= out_match_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_hit   = out_hit_q;
  assign bus.out_multi = out_multi_q;
  assign bus.out_match = out_match_q;

  // Counter increment requests; a multi-match also bumps its band counter.
  always_comb begin
    cnt_inc_s = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      cnt_inc_s[i] = hs_s && out_hit_q && (out_class_q == CLASS_W'(i));
    end
    cnt_inc_s[CNT_NM] = hs_s && !out_hit_q;
    cnt_inc_s[CNT_MU] = hs_s && out_multi_q;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    // Saturating statistics counter; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (stat_clr_i) begin
        cnt_q <= '0;
      end else if (cnt_inc_s[g] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign cnt_all_s[g] = cnt_q;
  end

  // Statistics read mux; unused select codes read as zero.
  always_comb begin
    stat_count_o = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (stat_sel_i == SEL_W'(i)) begin
        stat_count_o = cnt_all_s[i];
      end else begin
        stat_count_o = stat_count_o;
      end
    end
  end

endmodule

// File: tb/tb_range_band_classifier.sv
// -----------------------------------------------------------------------------
// tb_range_band_classifier
// Directed bench for range_band_classifier (WIDTH=8, NUM_BANDS=4, CNT_W=2).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// there too, so nothing is read at the active edge.
// -----------------------------------------------------------------------------
module tb_range_band_classifier;

  localparam int WIDTH = 8;
  localparam int NB    = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [1:0]       cfg_idx;
  logic [WIDTH-1:0] cfg_lo;
  logic [WIDTH-1:0] cfg_hi;
  logic             stat_clr;
  logic [2:0]       stat_sel;
  logic [CNT_W-1:0] stat_count;

  int total = 0;
  int bad   = 0;

  range_band_classifier_if #(.WIDTH(WIDTH), .NUM_BANDS(NB)) bus_if ();

  range_band_classifier #(
    .WIDTH     (WIDTH),
    .NUM_BANDS (NB),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_lo_i     (cfg_lo),
    .cfg_hi_i     (cfg_hi),
    .stat_clr_i   (stat_clr),
    .stat_sel_i   (stat_sel),
    .stat_count_o (stat_count),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [7:0] lo, input logic [7:0] hi);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_lo  = lo;
    cfg_hi  = hi;
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic stat(input logic [2:0] sel, input logic [31:0] exp, input string tag);
    stat_sel = sel;
    #1;
    chk(tag, 32'(stat_count), exp);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] cls, input logic [31:0] hit,
                         input logic [31:0] multi, input logic [31:0] match);
    chk({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
    chk({tag, "_class"}, 32'(bus_if.out_class), cls);
    chk({tag, "_hit"},   32'(bus_if.out_hit),   hit);
    chk({tag, "_multi"}, 32'(bus_if.out_multi), multi);
    chk({tag, "_match"}, 32'(bus_if.out_match), match);
  endtask

  // One sample with out_ready held high: accept, latency 2, handshake, drain.
  task automatic run1(input string tag, input logic [7:0] data, input logic [31:0] cls,
                      input logic [31:0] hit, input logic [31:0] multi, input logic [31:0] match);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = data;
    #1;
    chk({tag, "_inrdy"}, 32'(bus_if.in_ready), 32'd1);
    step();
    bus_if.in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(bus_if.out_valid), 32'd0);
    step();
    chk_out(tag, cls, hit, multi, match);
    step();
    chk({tag, "_drain"}, 32'(bus_if.out_valid), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    cfg_we           = 1'b0;
    cfg_idx          = 2'd0;
    cfg_lo           = 8'd0;
    cfg_hi           = 8'd0;
    stat_clr         = 1'b0;
    stat_sel         = 3'd0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'd0;
    bus_if.out_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_out_class", 32'(bus_if.out_class), 32'd0);
    chk("rst_out_hit",   32'(bus_if.out_hit),   32'd0);
    chk("rst_out_multi", 32'(bus_if.out_multi), 32'd0);
    chk("rst_out_match", 32'(bus_if.out_match), 32'd0);
    chk("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
    for (int s = 0; s < NB + 2; s++) begin
      stat(3'(s), 32'd0, "rst_cnt");
    end

    rst              = 1'b0;
    bus_if.out_ready = 1'b1;
    step();

    // Bands 0=[19,255], 1=[31,255], 2=[10,10], 3 left disabled
    cfg(2'd0, 8'd19, 8'd255);
    cfg(2'd1, 8'd31, 8'd255);
    cfg(2'd2, 8'd10, 8'd10);

    run1("nomatch17", 8'd17, 32'd0, 32'd0, 32'd0, 32'b0000);
    stat(3'd4, 32'd1, "cnt_nomatch_1");
    run1("multi40", 8'd40, 32'd0, 32'd1, 32'd1, 32'b0011);
    stat(3'd0, 32'd1, "cnt_band0_1");
    stat(3'd5, 32'd1, "cnt_multi_1");
    run1("exact10", 8'd10, 32'd2, 32'd1, 32'd0, 32'b0100);
    stat(3'd2, 32'd1, "cnt_band2_1");
    run1("lo_edge19", 8'd19, 32'd0, 32'd1, 32'd0, 32'b0001);
    run1("below18",   8'd18, 32'd0, 32'd0, 32'd0, 32'b0000);
    run1("edge31",    8'd31, 32'd0, 32'd1, 32'd1, 32'b0011);
    stat(3'd1, 32'd0, "cnt_band1_never_lowest");
    stat(3'd5, 32'd2, "cnt_multi_2");
    stat(3'd4, 32'd2, "cnt_nomatch_2");

    // Full stall: A=10, B=40, C=20 offered back-to-back with out_ready low
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 8'd10;
    #1;
    chk("stall_rdy_a", 32'(bus_if.in_ready), 32'd1);
    step();
    bus_if.in_data = 8'd40;
    chk("stall_rdy_b", 32'(bus_if.in_ready), 32'd1);
    step();
    bus_if.in_data = 8'd20;
    chk("stall_rdy_full", 32'(bus_if.in_ready), 32'd0);
    chk_out("stall_a", 32'd2, 32'd1, 32'd0, 32'b0100);
    step();
    chk("stall_rdy_hold", 32'(bus_if.in_ready), 32'd0);
    chk_out("stall_a_hold", 32'd2, 32'd1, 32'd0, 32'b0100);
    bus_if.out_ready = 1'b1;
    #1;
    chk("stall_rdy_release", 32'(bus_if.in_ready), 32'd1);
    step();
    bus_if.in_valid = 1'b0;
    chk_out("stall_b", 32'd0, 32'd1, 32'd1, 32'b0011);
    step();
    chk_out("stall_c", 32'd0, 32'd1, 32'd0, 32'b0001);
    step();
    chk("stall_drain", 32'(bus_if.out_valid), 32'd0);
    stat(3'd2, 32'd2, "cnt_band2_once");

    // Config write on the same cycle a sample of 5 is accepted
    cfg_we          = 1'b1;
    cfg_idx         = 2'd0;
    cfg_lo          = 8'd0;
    cfg_hi          = 8'd255;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'd5;
    #1;
    chk("cfg_rdy", 32'(bus_if.in_ready), 32'd1);
    step();
    cfg_we = 1'b0;
    step();
    bus_if.in_valid = 1'b0;
    chk_out("cfg_old_bounds", 32'd0, 32'd0, 32'd0, 32'b0000);
    step();
    chk_out("cfg_new_bounds", 32'd0, 32'd1, 32'd0, 32'b0001);
    step();

    // Saturation with CNT_W=2: five band-1 samples
    cfg(2'd0, 8'd255, 8'd0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    stat(3'd1, 32'd0, "clr_band1");
    stat(3'd4, 32'd0, "clr_nomatch");
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'd50;
    repeat (5) step();
    bus_if.in_valid = 1'b0;
    step();
    step();
    stat(3'd1, 32'd3, "sat_band1");
    stat(3'd0, 32'd0, "sat_band0_disabled");
    stat(3'd5, 32'd0, "sat_multi_none");

    // stat_clr coinciding with a handshake
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'd50;
    step();
    bus_if.in_valid = 1'b0;
    step();
    chk("clr_hs_valid", 32'(bus_if.out_valid), 32'd1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    stat(3'd1, 32'd0, "clr_wins");
    run1("after_clr", 8'd50, 32'd1, 32'd1, 32'd0, 32'b0010);
    stat(3'd1, 32'd1, "inc_after_clr");

    // Reset with two samples in flight
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'd50;
    step();
    step();
    chk("pre_rst_valid", 32'(bus_if.out_valid), 32'd1);
    rst             = 1'b1;
    bus_if.in_valid = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus_if.out_valid), 32'd0);
    step();
    chk("rst_next_valid", 32'(bus_if.out_valid), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rst_nothing_emerges", 32'(bus_if.out_valid), 32'd0);
    end
    stat(3'd1, 32'd0, "rst_cnt_band1");
    run1("rst_bands_disabled", 8'd50, 32'd0, 32'd0, 32'd0, 32'b0000);
    stat(3'd4, 32'd1, "rst_cnt_nomatch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
